// File: rtl/soc_async_core.sv
// soc_async_core
// Single-cycle, unpipelined 32-bit MIPS-style compute tile. Holds an 8-bit
// program counter, a 256x32 instruction memory, a 32x32 register file and a
// 256x32 data RAM. One instruction retires on each rising edge with p_enable
// high. lw/sw wait for the ram_enable grant.
//
// Ports
//   p_clk       in   sole clock, rising edge
//   reset       in   asynchronous, active-low; clears PC and registers
//   p_enable    in   1 = execute, 0 = freeze PC, registers and RAM
//   ram_enable  in   RAM access grant for lw/sw
//   load_we     in   preload write strobe (works regardless of p_enable)
//   load_sel    in   0 = instruction memory, 1 = data RAM
//   load_addr   in   preload address [7:0]
//   load_data   in   preload data [31:0]
//   dbg_addr    in   debug RAM read address [7:0]
//   dbg_data    out  ram[dbg_addr], combinational
//   pc          out  current program counter [7:0]
//   instr       out  imem[pc], combinational
//
// RAM handshake: a lw/sw in the current slot commits only on a rising edge
// where ram_enable is high; while ram_enable is low the PC holds and no
// register or RAM write happens, for as many cycles as the grant stays low.
module soc_async_core (
    input  logic        p_clk,
    input  logic        reset,
    input  logic        p_enable,
    input  logic        ram_enable,
    input  logic        load_we,
    input  logic        load_sel,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [7:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [7:0]  pc,
    output logic [31:0] instr
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_JR    = 6'b001110;
    localparam logic [5:0] FN_ADD   = 6'b000000;
    localparam logic [5:0] FN_SUB   = 6'b000001;

    logic [31:0] r_imem [0:255];
    logic [31:0] r_ram  [0:255];
    logic [31:0] r_regs [0:31];
    logic [7:0]  r_pc;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_sext;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_sum;
    logic [7:0]  w_target;
    logic [7:0]  w_mem_addr;
    logic [7:0]  w_next_pc;
    logic        w_reg_we;
    logic [4:0]  w_reg_addr;
    logic [31:0] w_reg_data;
    logic        w_is_mem;
    logic        w_ram_we;
    logic        w_stall;
    logic        w_commit;
    logic        w_ram_load;
    logic        w_sw_commit;

    assign pc       = r_pc;
    assign instr    = r_imem[r_pc];
    assign dbg_data = r_ram[dbg_addr];

    assign w_op     = instr[31:26];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_funct  = instr[5:0];
    assign w_sext   = {{16{instr[15]}}, instr[15:0]};
    assign w_target = instr[7:0];

    // R0 is never written, but force the read to zero so it does not depend
    // on the register array content.
    assign w_rs_val   = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
    assign w_rt_val   = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
    assign w_sum      = w_rs_val + w_sext;
    assign w_mem_addr = w_sum[7:0];

    always_comb begin
        w_next_pc  = r_pc + 8'd1;
        w_reg_we   = 1'b0;
        w_reg_addr = 5'd0;
        w_reg_data = 32'd0;
        w_is_mem   = 1'b0;
        w_ram_we   = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                if (w_funct == FN_ADD) begin
                    w_reg_we   = 1'b1;
                    w_reg_addr = w_rd;
                    w_reg_data = w_rs_val + w_rt_val;
                end else if (w_funct == FN_SUB) begin
                    w_reg_we   = 1'b1;
                    w_reg_addr = w_rd;
                    w_reg_data = w_rs_val - w_rt_val;
                end
            end
            OP_ADDI: begin
                w_reg_we   = 1'b1;
                w_reg_addr = w_rt;
                w_reg_data = w_sum;
            end
            OP_LW: begin
                w_is_mem   = 1'b1;
                w_reg_we   = 1'b1;
                w_reg_addr = w_rt;
                w_reg_data = r_ram[w_mem_addr];
            end
            OP_SW: begin
                w_is_mem = 1'b1;
                w_ram_we = 1'b1;
            end
            OP_BEQ:  if (w_rs_val == w_rt_val) w_next_pc = w_target;
            OP_BNE:  if (w_rs_val != w_rt_val) w_next_pc = w_target;
            OP_BGTZ: if (!w_rs_val[31] && (w_rs_val != 32'd0)) w_next_pc = w_target;
            OP_J:    w_next_pc = w_target;
            OP_JAL: begin
                w_reg_we   = 1'b1;
                w_reg_addr = w_rt;
                w_reg_data = {24'd0, r_pc};
                w_next_pc  = w_target;
            end
            OP_JR:   w_next_pc = w_mem_addr;
            default: ;
        endcase
    end

    assign w_stall    = w_is_mem & ~ram_enable;
    assign w_commit   = p_enable & ~w_stall;
    assign w_ram_load = load_we & load_sel;
    // The RAM block has no reset, so gate the store with reset to abort an
    // instruction caught by reset. A preload to the same address wins.
    assign w_sw_commit = w_commit & w_ram_we & reset &
                         ~(w_ram_load && (load_addr == w_mem_addr));

    always_ff @(posedge p_clk or negedge reset) begin
        if (!reset) begin
            r_pc <= 8'd0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_commit) begin
            r_pc <= w_next_pc;
            if (w_reg_we && (w_reg_addr != 5'd0)) begin
                r_regs[w_reg_addr] <= w_reg_data;
            end
        end
    end

    always_ff @(posedge p_clk) begin
        if (load_we && !load_sel) begin
            r_imem[load_addr] <= load_data;
        end
        if (w_ram_load) begin
            r_ram[load_addr] <= load_data;
        end
        if (w_sw_commit) begin
            r_ram[w_mem_addr] <= w_rt_val;
        end
    end

endmodule

// File: tb/tb_soc_async_core.sv
module tb_soc_async_core;

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_JR   = 6'b001110;

    logic        p_clk;
    logic        reset;
    logic        p_enable;
    logic        ram_enable;
    logic        load_we;
    logic        load_sel;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [7:0]  pc;
    logic [31:0] instr;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  addr_q[$];

    typedef struct packed {
        logic [31:0] ins;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  exp_pc;
        logic [31:0] exp_r3;
    } vec_t;

    vec_t vecs [16];

    soc_async_core dut (
        .p_clk      (p_clk),
        .reset      (reset),
        .p_enable   (p_enable),
        .ram_enable (ram_enable),
        .load_we    (load_we),
        .load_sel   (load_sel),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .pc         (pc),
        .instr      (instr)
    );

    // clock / reset block
    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    task automatic load_w(input logic sel, input logic [7:0] addr, input logic [31:0] data);
        load_sel  = sel;
        load_addr = addr;
        load_data = data;
        load_we   = 1'b1;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic check_pc(input string name, input logic [7:0] exp);
        check(name, {24'd0, pc}, {24'd0, exp});
    endtask

    task automatic check_ram(input string name, input logic [7:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check(name, dbg_data, exp);
    endtask

    task automatic sb_push(input logic [7:0] addr, input logic [31:0] val);
        addr_q.push_back(addr);
        exp_q.push_back(val);
    endtask

    task automatic sb_drain(input string name);
        logic [7:0]  a;
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            a = addr_q.pop_front();
            e = exp_q.pop_front();
            check_ram($sformatf("%s_ram%0d", name, a), a, e);
        end
    endtask

    initial begin
        logic [31:0] a_first;
        logic [31:0] jal_w;
        int          idx;
        int          sieve_n;
        int          budget;
        bit          is_p;

        reset      = 1'b0;
        p_enable   = 1'b0;
        ram_enable = 1'b1;
        load_we    = 1'b0;
        load_sel   = 1'b0;
        load_addr  = 8'd0;
        load_data  = 32'd0;
        dbg_addr   = 8'd0;
        #1;
        check_pc("reset_pc_initial", 8'd0);
        reset = 1'b1;

        // ---------------- table-driven single-instruction vectors
        vecs[0]  = '{enc_r(1, 2, 3, 6'd0), 16'd5,     16'hFFFD, 8'd3,  32'h0000_0002};
        vecs[1]  = '{enc_r(1, 2, 3, 6'd1), 16'd5,     16'hFFFD, 8'd3,  32'h0000_0008};
        vecs[2]  = '{enc_r(1, 2, 3, 6'd1), 16'hFFFD,  16'd5,    8'd3,  32'hFFFF_FFF8};
        vecs[3]  = '{enc_r(1, 2, 3, 6'd0), 16'h7FFF,  16'h7FFF, 8'd3,  32'h0000_FFFE};
        vecs[4]  = '{enc_r(1, 2, 3, 6'd0), 16'h8000,  16'h8000, 8'd3,  32'hFFFF_0000};
        vecs[5]  = '{enc_r(1, 2, 3, 6'd2), 16'd5,     16'd3,    8'd3,  32'h0000_0000};
        vecs[6]  = '{enc_i(OP_BEQ, 1, 2, 16'd40),  16'd4, 16'd4, 8'd40, 32'd0};
        vecs[7]  = '{enc_i(OP_BEQ, 1, 2, 16'd40),  16'd4, 16'd5, 8'd3,  32'd0};
        vecs[8]  = '{enc_i(OP_BNE, 1, 2, 16'd40),  16'd4, 16'd5, 8'd40, 32'd0};
        vecs[9]  = '{enc_i(OP_BNE, 1, 2, 16'd40),  16'd7, 16'd7, 8'd3,  32'd0};
        vecs[10] = '{enc_i(OP_BGTZ, 1, 2, 16'd40), 16'd1,    16'd0, 8'd40, 32'd0};
        vecs[11] = '{enc_i(OP_BGTZ, 1, 2, 16'd40), 16'd0,    16'd9, 8'd3,  32'd0};
        vecs[12] = '{enc_i(OP_BGTZ, 1, 2, 16'd40), 16'hFFFF, 16'd0, 8'd3,  32'd0};
        vecs[13] = '{enc_i(OP_BGTZ, 1, 2, 16'd40), 16'h8000, 16'd0, 8'd3,  32'd0};
        vecs[14] = '{enc_i(OP_J, 0, 0, 16'd40),    16'd1,    16'd2, 8'd40, 32'd0};
        vecs[15] = '{{6'b111111, 5'd1, 5'd2, 5'd3, 11'd0}, 16'd1, 16'd2, 8'd3, 32'd0};

        for (int v = 0; v < 16; v++) begin
            p_enable = 1'b0;
            load_w(1'b0, 8'd0,  enc_i(OP_ADDI, 0, 1, vecs[v].a));
            load_w(1'b0, 8'd1,  enc_i(OP_ADDI, 0, 2, vecs[v].b));
            load_w(1'b0, 8'd2,  vecs[v].ins);
            load_w(1'b0, 8'd3,  enc_i(OP_SW, 0, 3, 16'd200));
            load_w(1'b0, 8'd40, enc_i(OP_SW, 0, 3, 16'd200));
            load_w(1'b1, 8'd200, 32'h5A5A_5A5A);
            do_reset();
            p_enable = 1'b1;
            tick();
            tick();
            check_pc($sformatf("vec%0d_pc_before", v), 8'd2);
            tick();
            check_pc($sformatf("vec%0d_pc_after", v), vecs[v].exp_pc);
            tick();
            p_enable = 1'b0;
            sb_push(8'd200, vecs[v].exp_r3);
            sb_drain($sformatf("vec%0d", v));
        end

        // ---------------- ALU sequence with R0 write discard
        load_w(1'b0, 8'd0, enc_i(OP_ADDI, 0, 1, 16'd5));
        load_w(1'b0, 8'd1, enc_i(OP_ADDI, 0, 2, 16'hFFFD));
        load_w(1'b0, 8'd2, enc_r(1, 2, 3, 6'd0));
        load_w(1'b0, 8'd3, enc_r(1, 2, 4, 6'd1));
        load_w(1'b0, 8'd4, enc_i(OP_ADDI, 0, 0, 16'd7));
        load_w(1'b0, 8'd5, enc_i(OP_SW, 0, 3, 16'd10));
        load_w(1'b0, 8'd6, enc_i(OP_SW, 0, 4, 16'd11));
        load_w(1'b0, 8'd7, enc_i(OP_SW, 0, 0, 16'd12));
        load_w(1'b0, 8'd8, enc_i(OP_J, 0, 0, 16'd8));
        for (int i = 10; i < 13; i++) load_w(1'b1, 8'(i), 32'hFFFF_FFFF);
        do_reset();
        p_enable = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check_pc("alu_pc_end", 8'd8);
        p_enable = 1'b0;
        sb_push(8'd10, 32'd2);
        sb_push(8'd11, 32'd8);
        sb_push(8'd12, 32'd0);
        sb_drain("alu");

        // ---------------- reset mid-program: PC/regs cleared, memories kept
        for (int i = 0; i < 31; i++) begin
            load_w(1'b0, 8'(i), enc_i(OP_ADDI, 0, 5'(i + 1), 16'(i * 3 + 1)));
        end
        load_w(1'b0, 8'd31, enc_i(OP_J, 0, 0, 16'd31));
        a_first = enc_i(OP_ADDI, 0, 1, 16'd1);
        for (int i = 0; i < 32; i++) load_w(1'b1, 8'(100 + i), 32'hA5A5_0000 | 32'(i));
        do_reset();
        p_enable = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        check_pc("rst_pc_before", 8'd31);
        reset = 1'b0;
        #1;
        check_pc("rst_pc_async", 8'd0);
        check("rst_instr_imem0", instr, a_first);
        // Reloading under reset; imem[0] becomes a store that must not commit.
        for (int i = 0; i < 32; i++) load_w(1'b0, 8'(i), enc_i(OP_SW, 0, 5'(i), 16'(100 + i)));
        load_w(1'b0, 8'd32, enc_i(OP_J, 0, 0, 16'd32));
        check_pc("rst_pc_held", 8'd0);
        check_ram("rst_no_store", 8'd100, 32'hA5A5_0000);
        p_enable = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        check_pc("freeze_pc", 8'd0);
        check_ram("freeze_ram", 8'd100, 32'hA5A5_0000);
        p_enable = 1'b1;
        for (int i = 0; i < 33; i++) tick();
        check_pc("rst_dump_pc", 8'd32);
        p_enable = 1'b0;
        for (int i = 0; i < 32; i++) sb_push(8'(100 + i), 32'd0);
        sb_drain("rst_regs");

        // ---------------- jal / jr linkage
        for (int i = 0; i < 6; i++) load_w(1'b0, 8'(i), 32'd0);
        jal_w = enc_i(OP_JAL, 0, 31, 16'd50);
        load_w(1'b0, 8'd6,  jal_w);
        load_w(1'b0, 8'd7,  enc_i(OP_SW, 0, 31, 16'd20));
        load_w(1'b0, 8'd8,  enc_i(OP_J, 0, 0, 16'd8));
        load_w(1'b0, 8'd50, enc_i(OP_JR, 31, 0, 16'd1));
        load_w(1'b1, 8'd20, 32'hFFFF_FFFF);
        do_reset();
        p_enable = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_pc("jal_pc_at", 8'd6);
        check("jal_instr", instr, jal_w);
        tick();
        check_pc("jal_target", 8'd50);
        tick();
        check_pc("jr_target", 8'd7);
        tick();
        check_pc("jal_after_sw", 8'd8);
        p_enable = 1'b0;
        sb_push(8'd20, 32'd6);
        sb_drain("jal");

        // ---------------- RAM handshake stalls and load-vs-store collision
        load_w(1'b0, 8'd0, enc_i(OP_ADDI, 0, 1, 16'd77));
        load_w(1'b0, 8'd1, enc_i(OP_SW, 0, 1, 16'd30));
        load_w(1'b0, 8'd2, enc_i(OP_LW, 0, 2, 16'd31));
        load_w(1'b0, 8'd3, enc_i(OP_SW, 0, 2, 16'd32));
        load_w(1'b0, 8'd4, enc_i(OP_SW, 0, 2, 16'd33));
        load_w(1'b0, 8'd5, enc_i(OP_J, 0, 0, 16'd5));
        load_w(1'b1, 8'd30, 32'h0000_1111);
        load_w(1'b1, 8'd31, 32'h0000_2222);
        load_w(1'b1, 8'd32, 32'd0);
        load_w(1'b1, 8'd33, 32'd0);
        do_reset();
        ram_enable = 1'b0;
        p_enable   = 1'b1;
        tick();
        check_pc("hs_addi", 8'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_pc($sformatf("hs_sw_stall%0d", k), 8'd1);
        end
        check_ram("hs_sw_not_written", 8'd30, 32'h0000_1111);
        ram_enable = 1'b1;
        tick();
        check_pc("hs_sw_commit_pc", 8'd2);
        check_ram("hs_sw_commit_ram", 8'd30, 32'd77);
        ram_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_pc($sformatf("hs_lw_stall%0d", k), 8'd2);
        end
        ram_enable = 1'b1;
        tick();
        check_pc("hs_lw_commit_pc", 8'd3);
        load_w(1'b1, 8'd32, 32'h0000_BEEF);
        check_pc("hs_collide_pc", 8'd4);
        tick();
        check_pc("hs_end_pc", 8'd5);
        p_enable = 1'b0;
        sb_push(8'd32, 32'h0000_BEEF);
        sb_push(8'd33, 32'h0000_2222);
        sb_drain("hs");

        // ---------------- PC wrap-around
        load_w(1'b0, 8'd0,   enc_i(OP_J, 0, 0, 16'd255));
        load_w(1'b0, 8'd255, 32'd0);
        do_reset();
        p_enable = 1'b1;
        tick();
        check_pc("wrap_at_255", 8'd255);
        tick();
        check_pc("wrap_to_0", 8'd0);
        p_enable = 1'b0;

        // ---------------- prime sieve: main at 0..12, IsPrime at 50..62
        sieve_n = 10;
        load_w(1'b0, 8'd0,  enc_i(OP_LW, 0, 1, 16'd0));
        load_w(1'b0, 8'd1,  enc_i(OP_ADDI, 0, 2, 16'd2));
        load_w(1'b0, 8'd2,  enc_i(OP_ADDI, 0, 3, 16'd1));
        load_w(1'b0, 8'd3,  enc_r(2, 1, 4, 6'd1));
        load_w(1'b0, 8'd4,  enc_i(OP_BGTZ, 4, 0, 16'd12));
        load_w(1'b0, 8'd5,  enc_i(OP_JAL, 0, 31, 16'd50));
        load_w(1'b0, 8'd6,  enc_i(OP_BEQ, 5, 0, 16'd9));
        load_w(1'b0, 8'd7,  enc_i(OP_SW, 3, 2, 16'd0));
        load_w(1'b0, 8'd8,  enc_i(OP_ADDI, 3, 3, 16'd1));
        load_w(1'b0, 8'd9,  enc_i(OP_ADDI, 2, 2, 16'd1));
        load_w(1'b0, 8'd10, enc_i(OP_J, 0, 0, 16'd3));
        load_w(1'b0, 8'd11, 32'd0);
        load_w(1'b0, 8'd12, enc_i(OP_J, 0, 0, 16'd12));
        load_w(1'b0, 8'd50, enc_i(OP_ADDI, 0, 5, 16'd1));
        load_w(1'b0, 8'd51, enc_i(OP_ADDI, 0, 6, 16'd2));
        load_w(1'b0, 8'd52, enc_r(2, 6, 7, 6'd1));
        load_w(1'b0, 8'd53, enc_i(OP_BGTZ, 7, 0, 16'd55));
        load_w(1'b0, 8'd54, enc_i(OP_JR, 31, 0, 16'd1));
        load_w(1'b0, 8'd55, enc_r(2, 0, 8, 6'd0));
        load_w(1'b0, 8'd56, enc_r(8, 6, 8, 6'd1));
        load_w(1'b0, 8'd57, enc_i(OP_BGTZ, 8, 0, 16'd56));
        load_w(1'b0, 8'd58, enc_i(OP_BEQ, 8, 0, 16'd61));
        load_w(1'b0, 8'd59, enc_i(OP_ADDI, 6, 6, 16'd1));
        load_w(1'b0, 8'd60, enc_i(OP_J, 0, 0, 16'd52));
        load_w(1'b0, 8'd61, enc_r(0, 0, 5, 6'd0));
        load_w(1'b0, 8'd62, enc_i(OP_JR, 31, 0, 16'd1));
        load_w(1'b1, 8'd0, 32'(sieve_n));
        for (int i = 1; i < 6; i++) load_w(1'b1, 8'(i), 32'hCAFE_F00D);

        // Reference: primes up to N by trial division, then untouched slots.
        idx = 1;
        for (int n = 2; n <= sieve_n; n++) begin
            is_p = 1'b1;
            for (int d = 2; d < n; d++) if (n % d == 0) is_p = 1'b0;
            if (is_p) begin
                sb_push(8'(idx), 32'(n));
                idx++;
            end
        end
        for (int i = idx; i < 6; i++) sb_push(8'(i), 32'hCAFE_F00D);

        do_reset();
        ram_enable = 1'b1;
        p_enable   = 1'b1;
        budget     = 0;
        while ((pc != 8'd12) && (budget < 5000)) begin
            tick();
            budget++;
        end
        check_pc("sieve_reach_12", 8'd12);
        p_enable = 1'b0;
        sb_drain("sieve");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/soc_async_core.md
# soc_async_core

Single-clock, unpipelined 32-bit MIPS-style SoC core: an 8-bit-addressed program counter, 256×32 instruction memory, 32×32 register file, ALU/branch unit and 256×32 data RAM. Executes one instruction per enabled clock. It is the compute tile of the SoC. Firmware and data are preloaded through a load port, and results are inspected through a debug read port.

## Interface
- No parameters. Widths are fixed: data 32, address 8.
- `p_clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. Clears the PC and all registers.
- `p_enable`  in  1  high: the core executes; low: PC, registers and RAM hold.
- `ram_enable`  in  1  RAM access grant; `lw`/`sw` stall while low.
- `load_we`  in  1  preload write strobe.
- `load_sel`  in  1  0 = instruction memory, 1 = data RAM.
- `load_addr`  in  8  preload address.
- `load_data`  in  32  preload data.
- `dbg_addr`  in  8  debug RAM read address.
- `dbg_data`  out  32  combinational `ram[dbg_addr]`.
- `pc`  out  8  current program counter.
- `instr`  out  32  combinational `imem[pc]`.

## Operation
**Instruction fields**
- op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0], imm = [15:0].
- sext(imm) is sign-extended to 32 bits.
- Branch and jump targets are absolute: target = imm[7:0].

**Instruction set**
- 000000 R-type:
  - funct 000000 `add`: R[rd] = R[rs] + R[rt].
  - funct 000001 `sub`: R[rd] = R[rs] − R[rt].
  - Any other funct is a no-op. All-zero word = nop.
- 001000 `addi`: R[rt] = R[rs] + sext(imm).
- 100011 `lw`: R[rt] = ram[(R[rs] + sext(imm))[7:0]].
- 101011 `sw`: ram[(R[rs] + sext(imm))[7:0]] = R[rt].
- 000100 `beq`: if R[rs] == R[rt], pc = target.
- 000101 `bne`: if R[rs] != R[rt], pc = target.
- 000111 `bgtz`: if R[rs] > 0 (signed), pc = target.
- 000010 `j`: pc = target.
- 000011 `jal`: R[rt] = zero-extended current pc (the pc of the jal itself); pc = target.
- 001110 `jr`: pc = (R[rs] + sext(imm))[7:0]. The rt field is ignored.
- Any undefined opcode is a nop.

**General rules**
- All arithmetic is 32-bit two's complement, wrapping; there are no overflow traps.
- R0 reads as 0 and writes to it are discarded.
- Non-branching instructions set pc = pc + 1, wrapping from 255 to 0.
- Register file, imem and RAM reads are combinational.

**Reset and preload**
- Reset clears the PC and all registers. It does not touch imem, RAM or the load port.
- A `load_we` write lands on the rising edge regardless of `p_enable`.
- If a RAM load and an `sw` hit the same address in the same cycle, the load wins.

## Timing
- Single cycle per instruction: the PC, register write and RAM write all commit on the same rising edge when `p_enable` = 1.
- `lw` and `sw` commit only in a cycle with `ram_enable` = 1. Otherwise the PC holds and nothing is written (stall), with no limit on stall length.
- `p_enable` = 0 freezes all architectural state except the load port.
- Reset assertion takes effect immediately: `pc` = 0 and `instr` = imem[0] without a clock. Deassertion is synchronized: the first instruction executes on the first rising edge after release with `p_enable` = 1.
- Reset asserted mid-program aborts the current instruction; its writes are not committed.
- `dbg_data` and `instr` follow their address within the same cycle.

## Test plan
- **Reset:** load a program, pulse `reset` low → `pc` = 0 and all registers = 0, while imem and RAM contents are preserved.
- **ALU and R0:**
  - `addi R1,R0,5`, then `addi R2,R0,-3`, then `add R3,R1,R2`, then `sub R4,R1,R2`, then `addi R0,R0,7` → R3 = 2, R4 = 8, R0 = 0.
  - Store the results with `sw`, then check them through `dbg_data`.
- **Branches and jumps:**
  - `beq`, `bne` and `bgtz` with equal, unequal, positive, zero and negative operands → `pc` equals imm[7:0] when taken and pc + 1 when not.
  - `jal R31,50` at pc 6 → R31 = 6 and `pc` = 50; a following `jr R31,+1` → `pc` = 7.
- **RAM handshake:**
  - `sw` with `ram_enable` held low for 3 cycles → `pc` holds for 3 cycles and the RAM is unchanged; the write commits on the first edge with `ram_enable` high.
  - `lw` with `ram_enable` low stalls the same way.
- **Prime sieve:**
  - Preload ram[0] = 10 and the prime program: main at 0–11, IsPrime subroutine at 50–62 (`jal`/`jr` linkage through R31).
  - Run until `pc` = 12 → ram[1..4] = 2, 3, 5, 7 and ram[5] is untouched.
- **Wrap-around:** a nop at imem[255] → `pc` goes 255 → 0.
